// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one byte-wide UART transmitter among N_REQ
// requesters. Ownership is granted round-robin per message: a requester keeps
// the transmitter from its first byte until the byte flagged REQ_LAST has been
// sent. A watchdog releases the lock if the transmitter never reports busy.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int GNT_W   = 2,
  parameter int TIMEOUT = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N_REQ-1:0]   REQ_VALID,
  input  logic [N_REQ-1:0]   REQ_LAST,
  input  logic [8*N_REQ-1:0] REQ_DATA,
  output logic [N_REQ-1:0]   REQ_READY,
  input  logic               TX_BUSY,
  output logic [7:0]         TX_P_DATA,
  output logic               TX_DATA_VALID,
  output logic [GNT_W-1:0]   GNT_ID,
  output logic               GNT_ACTIVE,
  output logic               TIMEOUT_ERR,
  input  logic               ERR_CLR
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // no owner, arbitrating
    START = 2'd1,  // byte handed over, waiting for TX_BUSY to rise
    SEND  = 2'd2,  // transmitter busy with the byte
    HOLD  = 2'd3   // message unfinished, owner keeps the lock
  } state_e;

  localparam logic [GNT_W:0]   N_REQ_X  = (GNT_W+1)'(N_REQ);
  localparam logic [GNT_W-1:0] LAST_IDX = GNT_W'(N_REQ - 1);
  localparam logic [7:0]       CNT_MAX  = 8'(TIMEOUT - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  state_e           state_q, state_d;
  logic [GNT_W-1:0] ptr_q, ptr_d;        // requester with top priority
  logic [GNT_W-1:0] gnt_id_q, gnt_id_d;
  logic [7:0]       data_q, data_d;
  logic             dv_q, dv_d;
  logic             last_q, last_d;      // REQ_LAST of the byte in flight
  logic [7:0]       cnt_q, cnt_d;        // cycles spent in START
  logic             err_q, err_d;

  logic [2*N_REQ-1:0] rot_full;
  logic [N_REQ-1:0]   rot_valid;
  logic               any_valid;
  logic [GNT_W-1:0]   rr_off;
  logic [GNT_W:0]     rr_sum;
  logic [GNT_W-1:0]   rr_win;
  logic [GNT_W-1:0]   sel_id;
  logic               xfer;
  logic [7:0]         sel_data;
  logic               sel_last;
  logic               timeout_hit;
  logic               release_lock;

  // Round-robin search: rotate the valid vector so the pointer sits at bit 0,
  // take the lowest set bit, then rotate the offset back into an index.
  always_comb begin
    rot_full  = {REQ_VALID, REQ_VALID} >> ptr_q;
    rot_valid = rot_full[N_REQ-1:0];
    any_valid = 1'b0;
    rr_off    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        any_valid = 1'b1;
        rr_off    = GNT_W'(k);
      end
    end
    rr_sum = {1'b0, ptr_q} + {1'b0, rr_off};
    rr_win = (rr_sum >= N_REQ_X) ? GNT_W'(rr_sum - N_REQ_X) : rr_sum[GNT_W-1:0];
  end

  // Output decode: ready strobes and the selected requester's byte.
  // NOTE: every signal written in an always_comb gets a default on entry;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    REQ_READY = '0;
    sel_id    = gnt_id_q;
    if (!RST && !TX_BUSY) begin
      unique case (state_q)
        IDLE: begin
          if (any_valid) begin
            REQ_READY = ONE_HOT0 << rr_win;
            sel_id    = rr_win;
          end
        end
        HOLD:    REQ_READY = ONE_HOT0 << gnt_id_q;
        default: REQ_READY = '0;
      endcase
    end
    xfer     = |(REQ_VALID & REQ_READY);
    sel_data = REQ_DATA[{sel_id, 3'b000} +: 8];
    sel_last = REQ_LAST[sel_id];
  end

  // Next-state logic, including the watchdog and message-end lock release.
  always_comb begin
    state_d      = state_q;
    timeout_hit  = 1'b0;
    release_lock = 1'b0;
    unique case (state_q)
      IDLE: if (xfer) state_d = START;
      START: begin
        if (TX_BUSY) begin
          state_d = SEND;
        end else if (cnt_q == CNT_MAX) begin
          state_d      = IDLE;
          timeout_hit  = 1'b1;
          release_lock = 1'b1;
        end
      end
      SEND: begin
        if (!TX_BUSY) begin
          state_d      = last_q ? IDLE : HOLD;
          release_lock = last_q;
        end
      end
      HOLD:    if (xfer) state_d = START;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: byte capture, watchdog counter, pointer, error flag.
  always_comb begin
    data_d   = data_q;
    dv_d     = xfer;
    gnt_id_d = gnt_id_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    err_d    = err_q;
    if (xfer) begin
      data_d   = sel_data;
      gnt_id_d = sel_id;
      last_d   = sel_last;
      cnt_d    = '0;
    end else if (state_q == START && !TX_BUSY && !timeout_hit) begin
      cnt_d = cnt_q + 8'd1;
    end
    if (release_lock) begin
      ptr_d = (gnt_id_q == LAST_IDX) ? '0 : gnt_id_q + GNT_W'(1);
    end
    if (ERR_CLR) err_d = 1'b0;
    // A timeout in the same cycle as a clear still leaves the flag set.
    if (timeout_hit) err_d = 1'b1;
  end

  // State and datapath registers; reset drops any lock immediately.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_id_q <= '0;
      data_q   <= '0;
      dv_q     <= 1'b0;
      last_q   <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_id_q <= gnt_id_d;
      data_q   <= data_d;
      dv_q     <= dv_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign TX_P_DATA     = data_q;
  assign TX_DATA_VALID = dv_q;
  assign GNT_ID        = gnt_id_q;
  assign GNT_ACTIVE    = (state_q != IDLE);
  assign TIMEOUT_ERR   = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios plus randomized message
// traffic checked against a message-level round-robin reference model.
module tb_uart_tx_arbiter;

  localparam int N_REQ   = 4;
  localparam int GNT_W   = 2;
  localparam int TIMEOUT = 16;

  logic               CLK = 1'b0;
  logic               RST;
  logic [N_REQ-1:0]   REQ_VALID;
  logic [N_REQ-1:0]   REQ_LAST;
  logic [8*N_REQ-1:0] REQ_DATA;
  logic [N_REQ-1:0]   REQ_READY;
  logic               TX_BUSY;
  logic [7:0]         TX_P_DATA;
  logic               TX_DATA_VALID;
  logic [GNT_W-1:0]   GNT_ID;
  logic               GNT_ACTIVE;
  logic               TIMEOUT_ERR;
  logic               ERR_CLR;

  uart_tx_arbiter #(.N_REQ(N_REQ), .GNT_W(GNT_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_LAST(REQ_LAST), .REQ_DATA(REQ_DATA),
    .REQ_READY(REQ_READY), .TX_BUSY(TX_BUSY), .TX_P_DATA(TX_P_DATA),
    .TX_DATA_VALID(TX_DATA_VALID), .GNT_ID(GNT_ID), .GNT_ACTIVE(GNT_ACTIVE),
    .TIMEOUT_ERR(TIMEOUT_ERR), .ERR_CLR(ERR_CLR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Requester sources: each entry is {last, data}.
  logic [8:0] src_q [N_REQ][$];
  bit         mid [N_REQ];          // requester is part-way through a message
  int         gap_pct  = 0;         // chance of a valid gap inside a message
  bit         chk_blk3 = 1'b0;

  // Transmitter model.
  bit tx_auto = 1'b0;
  bit tx_rand = 1'b0;
  int tx_len  = 1;
  int tx_left = 0;
  bit tx_pend = 1'b0;

  // Observed and expected transmitted bytes.
  int sent_id[$];
  int sent_data[$];
  int exp_id[$];
  int exp_data[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N_REQ; i++) begin
      bit gap;
      gap = mid[i] && ($urandom_range(99, 0) < gap_pct);
      if (src_q[i].size() > 0 && !gap) begin
        REQ_VALID[i]      = 1'b1;
        REQ_DATA[8*i +: 8] = src_q[i][0][7:0];
        REQ_LAST[i]       = src_q[i][0][8];
      end else begin
        REQ_VALID[i]      = 1'b0;
        REQ_DATA[8*i +: 8] = 8'($urandom);
        REQ_LAST[i]       = 1'($urandom);
      end
    end
  endtask

  // One clock cycle: observe the handshake at the falling edge, check the
  // registered response just after the rising edge, then update stimulus.
  task automatic tick();
    logic             hs;
    logic [GNT_W-1:0] hi;
    logic [7:0]       hd;
    logic             hl;
    @(negedge CLK);
    hs = 1'b0; hi = '0; hd = '0; hl = 1'b0;
    if (chk_blk3 && src_q[1].size() > 0) check("hold_blocks_req3", REQ_READY[3], 1'b0);
    for (int i = 0; i < N_REQ; i++) begin
      if (REQ_VALID[i] && REQ_READY[i]) begin
        hs = 1'b1; hi = GNT_W'(i); hd = REQ_DATA[8*i +: 8]; hl = REQ_LAST[i];
      end
    end
    @(posedge CLK);
    #1;
    check("dv_after_handshake", TX_DATA_VALID, hs);
    if (hs) begin
      check("gnt_id_after_handshake", GNT_ID, hi);
      check("p_data_after_handshake", TX_P_DATA, hd);
      check("gnt_active_after_handshake", GNT_ACTIVE, 1'b1);
      if (src_q[hi].size() > 0) void'(src_q[hi].pop_front());
      mid[hi] = !hl;
    end
    if (TX_DATA_VALID) begin
      sent_id.push_back(int'(GNT_ID));
      sent_data.push_back(int'(TX_P_DATA));
    end
    if (tx_auto) begin
      if (tx_pend) begin
        if (tx_rand) tx_len = $urandom_range(4, 1);
        TX_BUSY = 1'b1;
        tx_left = tx_len - 1;
      end else if (tx_left > 0) begin
        tx_left--;
      end else begin
        TX_BUSY = 1'b0;
      end
      tx_pend = TX_DATA_VALID;
    end
    drive();
  endtask

  task automatic run_until(input int n, input int budget);
    int k;
    k = 0;
    while (sent_id.size() < n && k < budget) begin
      tick();
      k++;
    end
    check("drain_count", sent_id.size(), n);
  endtask

  task automatic wait_dv(input string tag, input int budget);
    int k;
    k = 0;
    while (!TX_DATA_VALID && k < budget) begin
      tick();
      k++;
    end
    check(tag, TX_DATA_VALID, 1'b1);
  endtask

  task automatic check_seq(input string tag);
    check({tag, "_len"}, sent_id.size(), exp_id.size());
    for (int i = 0; i < exp_id.size() && i < sent_id.size(); i++) begin
      check({tag, "_id"}, sent_id[i], exp_id[i]);
      check({tag, "_data"}, sent_data[i], exp_data[i]);
    end
  endtask

  task automatic expect_byte(input int id, input int data);
    exp_id.push_back(id);
    exp_data.push_back(data);
  endtask

  task automatic do_reset();
    RST = 1'b1; ERR_CLR = 1'b0;
    tx_auto = 1'b0; tx_rand = 1'b0; TX_BUSY = 1'b0; tx_left = 0; tx_pend = 1'b0;
    gap_pct = 0; chk_blk3 = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      src_q[i].delete();
      mid[i] = 1'b0;
    end
    drive();
    tick();
    tick();
    RST = 1'b0;
    sent_id.delete(); sent_data.delete(); exp_id.delete(); exp_data.delete();
    drive();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},    REQ_READY, '0);
    check({tag, "_p_data"},   TX_P_DATA, 8'h00);
    check({tag, "_dv"},       TX_DATA_VALID, 1'b0);
    check({tag, "_gnt_id"},   GNT_ID, '0);
    check({tag, "_active"},   GNT_ACTIVE, 1'b0);
    check({tag, "_err"},      TIMEOUT_ERR, 1'b0);
  endtask

  // Random messages per requester, expected order from a message-level
  // round-robin: the owner sends its whole message, then priority moves on.
  task automatic random_round();
    logic [8:0] mq [N_REQ][$];
    int  ptr;
    bit  any;
    int  total;
    total = 0;
    for (int i = 0; i < N_REQ; i++) begin
      int nmsg;
      nmsg = $urandom_range(3, 0);
      for (int m = 0; m < nmsg; m++) begin
        int nb;
        nb = $urandom_range(4, 1);
        for (int b = 0; b < nb; b++) begin
          src_q[i].push_back({(b == nb - 1), 8'($urandom)});
          total++;
        end
      end
      mq[i] = src_q[i];
    end
    ptr = 0;
    do begin
      any = 1'b0;
      for (int k = 0; k < N_REQ && !any; k++) begin
        int i;
        logic [8:0] b;
        i = (ptr + k) % N_REQ;
        if (mq[i].size() > 0) begin
          any = 1'b1;
          do begin
            b = mq[i].pop_front();
            expect_byte(i, int'(b[7:0]));
          end while (!b[8]);
          ptr = (i + 1) % N_REQ;
        end
      end
    end while (any);
    gap_pct = 30;
    tx_auto = 1'b1;
    tx_rand = 1'b1;
    drive();
    run_until(total, 3000);
    check_seq("random_order");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values with every requester presenting a byte.
    RST = 1'b1; ERR_CLR = 1'b0; TX_BUSY = 1'b0;
    for (int i = 0; i < N_REQ; i++) src_q[i].push_back({1'b1, 8'(8'hE0 + i)});
    drive();
    #2;
    check_reset_outputs("reset");
    tick();
    check_reset_outputs("reset_held");

    // Single-byte messages from requesters 0 and 2 alternate.
    do_reset();
    src_q[0].push_back({1'b1, 8'hA0}); src_q[0].push_back({1'b1, 8'hA1});
    src_q[2].push_back({1'b1, 8'hB0}); src_q[2].push_back({1'b1, 8'hB1});
    tx_auto = 1'b1; tx_len = 10;
    drive();
    #1;
    check("first_ready_0101", REQ_READY, 4'b0001);
    run_until(4, 200);
    expect_byte(0, 8'hA0); expect_byte(2, 8'hB0); expect_byte(0, 8'hA1); expect_byte(2, 8'hB1);
    check_seq("alt_0_2");

    // Multi-byte message from requester 1 holds off requester 3.
    do_reset();
    src_q[1].push_back({1'b0, 8'h41}); src_q[1].push_back({1'b0, 8'h42});
    src_q[1].push_back({1'b1, 8'h43});
    src_q[3].push_back({1'b1, 8'h77});
    tx_auto = 1'b1; tx_len = 3; gap_pct = 50; chk_blk3 = 1'b1;
    drive();
    run_until(4, 300);
    chk_blk3 = 1'b0;
    expect_byte(1, 8'h41); expect_byte(1, 8'h42); expect_byte(1, 8'h43); expect_byte(3, 8'h77);
    check_seq("hold_msg");

    // Watchdog: TX_BUSY never rises after requester 2's byte.
    do_reset();
    src_q[2].push_back({1'b1, 8'h5A});
    drive();
    wait_dv("timeout_dv_seen", 20);
    for (int k = 1; k < TIMEOUT; k++) begin
      tick();
      check("timeout_not_yet", TIMEOUT_ERR, 1'b0);
    end
    tick();
    check("timeout_err_set", TIMEOUT_ERR, 1'b1);
    check("timeout_lock_dropped", GNT_ACTIVE, 1'b0);
    sent_id.delete(); sent_data.delete();
    src_q[0].push_back({1'b1, 8'h30});
    src_q[3].push_back({1'b1, 8'h33});
    tx_auto = 1'b1; tx_len = 3;
    drive();
    #1;
    check("after_timeout_ready_req3", REQ_READY, 4'b1000);
    run_until(2, 100);
    expect_byte(3, 8'h33); expect_byte(0, 8'h30);
    check_seq("after_timeout");
    check("timeout_err_sticky", TIMEOUT_ERR, 1'b1);
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    check("timeout_err_cleared", TIMEOUT_ERR, 1'b0);
    for (int k = 0; k < 10; k++) tick();
    // Clear and a new timeout in the same cycle: the flag stays set.
    tx_auto = 1'b0; TX_BUSY = 1'b0;
    src_q[1].push_back({1'b1, 8'h51});
    drive();
    wait_dv("set_wins_dv_seen", 20);
    for (int k = 1; k < TIMEOUT; k++) tick();
    check("set_wins_pre", TIMEOUT_ERR, 1'b0);
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    check("set_wins_over_clear", TIMEOUT_ERR, 1'b1);

    // External busy in IDLE suppresses every ready until it drops.
    do_reset();
    TX_BUSY = 1'b1;
    for (int i = 0; i < N_REQ; i++) src_q[i].push_back({1'b1, 8'(8'hC0 + i)});
    drive();
    #1;
    check("busy_idle_ready", REQ_READY, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("busy_idle_ready_held", REQ_READY, 4'b0000);
    end
    TX_BUSY = 1'b0;
    #1;
    check("busy_released_ready", REQ_READY, 4'b0001);
    tx_auto = 1'b1; tx_len = 2;
    run_until(4, 200);
    for (int i = 0; i < N_REQ; i++) expect_byte(i, 8'hC0 + i);
    check_seq("busy_then_grant");

    // All requesters always valid: strict rotation with wrap-around.
    do_reset();
    for (int i = 0; i < N_REQ; i++) begin
      src_q[i].push_back({1'b1, 8'(8'h60 + i)});
      src_q[i].push_back({1'b1, 8'(8'h70 + i)});
    end
    tx_auto = 1'b1; tx_len = 1;
    drive();
    run_until(8, 300);
    for (int i = 0; i < N_REQ; i++) expect_byte(i, 8'h60 + i);
    for (int i = 0; i < N_REQ; i++) expect_byte(i, 8'h70 + i);
    check_seq("rotation");

    // Reset during SEND of requester 1's first (non-last) byte.
    do_reset();
    src_q[1].push_back({1'b0, 8'h11}); src_q[1].push_back({1'b1, 8'h12});
    tx_auto = 1'b1; tx_len = 6;
    drive();
    wait_dv("rst_send_dv_seen", 20);
    tick(); tick(); tick();
    check("rst_send_active_before", GNT_ACTIVE, 1'b1);
    RST = 1'b1;
    TX_BUSY = 1'b0; tx_left = 0; tx_pend = 1'b0;
    for (int i = 0; i < N_REQ; i++) mid[i] = 1'b0;
    src_q[0].push_back({1'b1, 8'h0A});
    drive();
    #1;
    check_reset_outputs("rst_mid_send");
    tick();
    tick();
    RST = 1'b0;
    sent_id.delete(); sent_data.delete();
    drive();
    #1;
    check("rst_release_ready_req0", REQ_READY, 4'b0001);
    run_until(2, 200);
    expect_byte(0, 8'h0A); expect_byte(1, 8'h12);
    check_seq("after_rst");

    // Randomized message traffic.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      random_round();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning the number of byte-stream requesters sharing one UART transmitter (2..8).
REQ-002 SHALL have parameter GNT_W, default 2, meaning the grant index width; it SHALL equal clog2(N_REQ).
REQ-003 SHALL have parameter TIMEOUT, default 16, meaning the maximum cycles from TX_DATA_VALID to TX_BUSY rising (2..255).
REQ-004 SHALL have the port CLK  input  1  the single system clock; all logic is on its rising edge.
REQ-005 SHALL have the port RST  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have the port REQ_VALID  input  N_REQ  per-requester byte-available flag.
REQ-007 SHALL have the port REQ_LAST  input  N_REQ  per-requester flag marking the final byte of a message.
REQ-008 SHALL have the port REQ_DATA  input  8*N_REQ  per-requester byte, requester i on bits [8i+7:8i].
REQ-009 SHALL have the port REQ_READY  output  N_REQ  per-requester accept strobe, combinational from state and registers.
REQ-010 SHALL have the port TX_BUSY  input  1  transmitter busy status.
REQ-011 SHALL have the port TX_P_DATA  output  8  registered byte to the transmitter.
REQ-012 SHALL have the port TX_DATA_VALID  output  1  registered one-cycle start strobe to the transmitter.
REQ-013 SHALL have the port GNT_ID  output  GNT_W  index of the current or most recent owner.
REQ-014 SHALL have the port GNT_ACTIVE  output  1  high while any requester owns the transmitter.
REQ-015 SHALL have the port TIMEOUT_ERR  output  1  sticky flag: TX_BUSY failed to rise in time.
REQ-016 SHALL have the port ERR_CLR  input  1  synchronous clear of TIMEOUT_ERR.

Function
REQ-017 SHALL implement the states IDLE, START, SEND and HOLD.
REQ-018 IDLE: when TX_BUSY=0 and any REQ_VALID=1, REQ_READY SHALL be asserted for exactly one winner, chosen round-robin starting at the index after the last completed owner and wrapping from N_REQ-1 to 0.
REQ-019 IDLE with TX_BUSY=1: REQ_READY SHALL be all zero.
REQ-020 A byte SHALL transfer in a cycle where REQ_VALID[i] and REQ_READY[i] are both 1.
REQ-021 The cycle after a transfer: TX_P_DATA SHALL hold that byte, TX_DATA_VALID SHALL be 1 for that cycle only, GNT_ID SHALL be i, GNT_ACTIVE SHALL be 1, and the state SHALL be START. Latency is 1 cycle.
REQ-022 TX_P_DATA SHALL stay stable until the next transfer.
REQ-023 START: a counter SHALL count cycles since TX_DATA_VALID. TX_BUSY=1 SHALL move the FSM to SEND. If the counter reaches TIMEOUT with TX_BUSY still 0:
- TIMEOUT_ERR SHALL be set;
- the lock SHALL be released;
- the pointer SHALL advance past GNT_ID;
- the FSM SHALL return to IDLE.
REQ-024 SEND: on TX_BUSY falling to 0, the FSM SHALL go to IDLE and advance the pointer if the transferred byte had REQ_LAST=1; otherwise it SHALL go to HOLD.
REQ-025 HOLD: only REQ_READY[GNT_ID] SHALL be asserted, and only while TX_BUSY=0. A transfer SHALL proceed as in REQ-021. Other requesters SHALL be blocked. HOLD has no timeout. GNT_ACTIVE SHALL remain 1.
REQ-026 REQ_READY SHALL be zero in START and SEND.
REQ-027 If ERR_CLR and a new timeout occur in the same cycle, the set SHALL win.
REQ-028 Changes on REQ_VALID or REQ_DATA for requesters that are not granted SHALL have no effect.

Reset
REQ-029 While RST=1, the block SHALL hold these values:
- state IDLE;
- REQ_READY=0, TX_P_DATA=0, TX_DATA_VALID=0, GNT_ID=0, GNT_ACTIVE=0, TIMEOUT_ERR=0;
- counter 0;
- round-robin pointer set so that requester 0 has top priority.
REQ-030 Assertion of RST mid-transfer or mid-HOLD SHALL abort immediately: the lock is dropped, no further TX_DATA_VALID is issued, and no byte is lost or duplicated after release.

Verification
REQ-031 Out of reset, REQ_VALID=4'b0101 with single-byte messages (LAST=1) and a TX_BUSY model high for 10 cycles -> grant order 0,2,0,2; each TX_DATA_VALID appears exactly 1 cycle after its handshake.
REQ-032 Requester 1 sends 3 bytes 0x41,0x42,0x43 (LAST on 0x43) while requester 3 holds REQ_VALID=1 -> TX_P_DATA sequence 0x41,0x42,0x43 then requester 3's byte; REQ_READY[3]=0 throughout HOLD.
REQ-033 TX_BUSY tied to 0 after a handshake by requester 2 -> TIMEOUT_ERR=1 exactly TIMEOUT cycles after TX_DATA_VALID; FSM in IDLE; next grant goes to requester 3; ERR_CLR=1 then clears the flag.
REQ-034 TX_BUSY=1 externally while in IDLE with REQ_VALID=4'b1111 -> REQ_READY=0 until TX_BUSY=0, then one grant.
REQ-035 RST pulsed during SEND of a non-LAST byte by requester 1 -> all outputs at reset values; after release requester 0 wins first if valid.
REQ-036 All four requesters continuously valid with LAST=1 -> grants 0,1,2,3,0 (wrap-around), with no requester skipped.
